// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: 32-iteration unsigned shift-add multiply / restoring
// divide controller. Borrows the shared EX-stage ALU for one add or subtract
// per cycle and holds the 64-bit HI/LO result registers.
// Optional feature macro: MULDIV_DIV_EN (defined = DIVU supported; undefined =
// every start performs MULTU and op is ignored).
module muldiv_sequencer #(
  parameter logic [2:0]  CTL_ADD = 3'b010,
  parameter logic [2:0]  CTL_SUB = 3'b110,
  parameter int unsigned ITER    = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op,
  input  logic        flush,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  input  logic [31:0] aluResult,
  output logic [31:0] aluA,
  output logic [31:0] aluB,
  output logic [2:0]  aluCtl,
  output logic        aluOwn,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [4:0] LAST = 5'(ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_count;
  logic [31:0] r_m;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  // Multiply step: carry out of hi+M is rebuilt from operand/result MSBs
  logic        w_mul_c;
  logic [32:0] w_mul_t;
  logic [31:0] w_mul_hi;
  logic [31:0] w_mul_lo;

  // Per-iteration ALU drive and next HI/LO, selected by the active operation
  logic [31:0] w_run_a;
  logic [2:0]  w_run_ctl;
  logic [31:0] w_nxt_hi;
  logic [31:0] w_nxt_lo;

  assign w_mul_c  = (r_hi[31] & r_m[31]) | ((r_hi[31] | r_m[31]) & ~aluResult[31]);
  assign w_mul_t  = r_lo[0] ? {w_mul_c, aluResult} : {1'b0, r_hi};
  assign w_mul_hi = w_mul_t[32:1];
  assign w_mul_lo = {w_mul_t[0], r_lo[31:1]};

`ifdef MULDIV_DIV_EN
  logic        r_op;
  logic [31:0] w_div_r;
  logic        w_div_nb;
  logic        w_div_take;

  // Partial remainder is 33 bits wide ({hi, lo[31]}); a set hi[31] means it
  // already exceeds any 32-bit divisor, so the subtract is always taken then.
  assign w_div_r    = {r_hi[30:0], r_lo[31]};
  assign w_div_nb   = (w_div_r[31] & ~r_m[31]) | (~(w_div_r[31] ^ r_m[31]) & ~aluResult[31]);
  assign w_div_take = r_hi[31] | w_div_nb;

  // Choose multiply or divide iteration for the latched operation
  always_comb begin
    w_run_a   = r_hi;
    w_run_ctl = CTL_ADD;
    w_nxt_hi  = w_mul_hi;
    w_nxt_lo  = w_mul_lo;
    if (r_op) begin
      w_run_a   = w_div_r;
      w_run_ctl = CTL_SUB;
      w_nxt_hi  = w_div_take ? aluResult : w_div_r;
      w_nxt_lo  = {r_lo[30:0], w_div_take};
    end
  end
`else
  logic [3:0] w_unused;

  assign w_unused  = {op, CTL_SUB};
  assign w_run_a   = r_hi;
  assign w_run_ctl = CTL_ADD;
  assign w_nxt_hi  = w_mul_hi;
  assign w_nxt_lo  = w_mul_lo;
`endif

  assign hi = r_hi;
  assign lo = r_lo;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and ALU/handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    aluOwn      = 1'b0;
    done        = 1'b0;
    aluA        = '0;
    aluB        = '0;
    aluCtl      = CTL_ADD;
    case (r_state)
      S_IDLE: begin
        if (start && !flush) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy   = 1'b1;
        aluOwn = 1'b1;
        aluA   = w_run_a;
        aluB   = r_m;
        aluCtl = w_run_ctl;
        if (flush) begin
          w_state_nxt = S_IDLE;
        end else if (r_count == LAST) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        busy        = 1'b1;
        done        = !flush;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand latch, iteration counter and HI/LO update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_m     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
`ifdef MULDIV_DIV_EN
      r_op    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && !flush) begin
            r_m     <= srcB;
            r_hi    <= '0;
            r_lo    <= srcA;
            r_count <= '0;
`ifdef MULDIV_DIV_EN
            r_op    <= op;
`endif
          end
        end
        S_RUN: begin
          if (!flush) begin
            r_hi    <= w_nxt_hi;
            r_lo    <= w_nxt_lo;
            r_count <= r_count + 5'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer. The shared ALU is
// modelled behaviourally from aluA/aluB/aluCtl.
module tb_muldiv_sequencer;

  localparam logic [2:0] ADD = 3'b010;
  localparam logic [2:0] SUB = 3'b110;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        op;
  logic        flush;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic [31:0] aluResult;
  logic [31:0] aluA;
  logic [31:0] aluB;
  logic [2:0]  aluCtl;
  logic        aluOwn;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  muldiv_sequencer #(.CTL_ADD(3'b010), .CTL_SUB(3'b110), .ITER(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .flush(flush),
    .srcA(srcA), .srcB(srcB), .aluResult(aluResult),
    .aluA(aluA), .aluB(aluB), .aluCtl(aluCtl), .aluOwn(aluOwn),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  assign aluResult = (aluCtl == SUB) ? (aluA - aluB) : (aluA + aluB);

  // Launch one operation and collect observations until done (bounded)
  task automatic run_op(input logic i_op, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] ectl,
                        output int lat, output int own, output int ctlbad);
    @(negedge clk);
    start = 1'b1; op = i_op; srcA = a; srcB = b;
    lat = 0; own = 0; ctlbad = 0;
    do begin
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
      if (aluOwn) begin
        own++;
        if (aluCtl !== ectl) ctlbad++;
      end
    end while (!done && lat < 100);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({busy, done, aluOwn} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl got %b exp 000", {busy, done, aluOwn});
    end
    checks++;
    if ({hi, lo} !== 64'h0) begin
      errors++; $display("FAIL reset_hilo got %h exp 0", {hi, lo});
    end
    checks++;
    if ({aluA, aluB, aluCtl} !== {32'h0, 32'h0, ADD}) begin
      errors++; $display("FAIL reset_alu got %h %h %b exp 0 0 010", aluA, aluB, aluCtl);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mul_max();
    int lat, own, bad;
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ADD, lat, own, bad);
    checks++;
    if (lat != 33) begin errors++; $display("FAIL mulmax_latency got %0d exp 33", lat); end
    checks++;
    if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin
      errors++; $display("FAIL mulmax_result got %h exp fffffffe00000001", {hi, lo});
    end
    checks++;
    if (own != 32 || bad != 0) begin
      errors++; $display("FAIL mulmax_own got own=%0d badctl=%0d exp 32 0", own, bad);
    end
    checks++;
    if (aluOwn !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL mulmax_done_state got own=%b busy=%b exp 0 1", aluOwn, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL mulmax_idle got busy=%b done=%b exp 0 0", busy, done);
    end
  endtask

  task automatic test_mul_basic();
    int lat, own, bad;
    run_op(1'b0, 32'h1234_5678, 32'h0000_0010, ADD, lat, own, bad);
    checks++;
    if ({hi, lo} !== 64'h0000_0001_2345_6780 || lat != 33) begin
      errors++; $display("FAIL mul_basic got %h lat=%0d exp 0000000123456780 33", {hi, lo}, lat);
    end
    @(posedge clk); #1;
  endtask

`ifdef MULDIV_DIV_EN
  task automatic test_divide();
    int lat, own, bad;
    run_op(1'b1, 32'd100, 32'd7, SUB, lat, own, bad);
    checks++;
    if (lo !== 32'd14 || hi !== 32'd2) begin
      errors++; $display("FAIL div_100_7 got lo=%0d hi=%0d exp 14 2", lo, hi);
    end
    checks++;
    if (own != 32 || bad != 0) begin
      errors++; $display("FAIL div_own got own=%0d badctl=%0d exp 32 0", own, bad);
    end
    @(posedge clk); #1;
    run_op(1'b1, 32'h8000_0000, 32'd3, SUB, lat, own, bad);
    checks++;
    if (lo !== 32'h2AAA_AAAA || hi !== 32'd2) begin
      errors++; $display("FAIL div_big got lo=%h hi=%h exp 2aaaaaaa 2", lo, hi);
    end
    @(posedge clk); #1;
    run_op(1'b1, 32'h1234_5678, 32'd0, SUB, lat, own, bad);
    checks++;
    if (lo !== 32'hFFFF_FFFF || hi !== 32'h1234_5678 || lat != 33) begin
      errors++; $display("FAIL div_zero got lo=%h hi=%h lat=%0d exp ffffffff 12345678 33", lo, hi, lat);
    end
    @(posedge clk); #1;
  endtask
`else
  task automatic test_divide_disabled();
    int lat, own, bad;
    run_op(1'b1, 32'd5, 32'd9, ADD, lat, own, bad);
    checks++;
    if (lo !== 32'd45 || hi !== 32'd0) begin
      errors++; $display("FAIL nodiv_mul got lo=%0d hi=%0d exp 45 0", lo, hi);
    end
    checks++;
    if (own != 32 || bad != 0 || lat != 33) begin
      errors++; $display("FAIL nodiv_ctl got own=%0d badctl=%0d lat=%0d exp 32 0 33", own, bad, lat);
    end
    @(posedge clk); #1;
  endtask
`endif

  task automatic test_start_held();
    int lat;
    @(negedge clk);
    start = 1'b1; op = 1'b0; srcA = 32'd6; srcB = 32'd7;
    @(posedge clk); #1;
    srcA = 32'd3; srcB = 32'd3;
    lat = 1;
    while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat != 33 || hi !== 32'd0 || lo !== 32'd42) begin
      errors++; $display("FAIL held_first got lat=%0d hi=%0d lo=%0d exp 33 0 42", lat, hi, lo);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL held_idle got busy=%b done=%b exp 0 0", busy, done);
    end
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || lo !== 32'd3) begin
      errors++; $display("FAIL held_reaccept got busy=%b lo=%0d exp 1 3", busy, lo);
    end
    lat = 1;
    while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat != 33 || lo !== 32'd9 || hi !== 32'd0) begin
      errors++; $display("FAIL held_second got lat=%0d lo=%0d hi=%0d exp 33 9 0", lat, lo, hi);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_abort_rst();
    int seen;
    @(negedge clk);
    start = 1'b1; op = 1'b0; srcA = 32'hFFFF_FFFF; srcB = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, aluOwn} !== 3'b000 || {hi, lo} !== 64'h0 || aluA !== 32'h0 || aluB !== 32'h0) begin
      errors++; $display("FAIL abort_rst got busy=%b own=%b hi=%h lo=%h a=%h b=%h exp all 0",
                         busy, aluOwn, hi, lo, aluA, aluB);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (done || busy) seen++; end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL abort_rst_quiet got %0d active cycles exp 0", seen); end
  endtask

  task automatic test_abort_flush();
    int seen, lat, own, bad;
    @(negedge clk);
    start = 1'b1; op = 1'b0; srcA = 32'hFFFF_FFFF; srcB = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if ({busy, done, aluOwn} !== 3'b000) begin
      errors++; $display("FAIL flush_run got busy/done/own=%b exp 000", {busy, done, aluOwn});
    end
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (done || busy) seen++; end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL flush_quiet got %0d active cycles exp 0", seen); end
    // flush in DONE suppresses the pulse combinationally
    run_op(1'b0, 32'd2, 32'd3, ADD, lat, own, bad);
    flush = 1'b1;
    #1;
    checks++;
    if (done !== 1'b0 || lo !== 32'd6) begin
      errors++; $display("FAIL flush_done got done=%b lo=%0d exp 0 6", done, lo);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    // flush beats start in IDLE
    @(negedge clk);
    start = 1'b1; flush = 1'b1; srcA = 32'd1; srcB = 32'd1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || lo !== 32'd6) begin
      errors++; $display("FAIL flush_idle got busy=%b lo=%0d exp 0 6", busy, lo);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 1'b0; flush = 1'b0; srcA = '0; srcB = '0;
    test_reset();
    test_mul_max();
    test_mul_basic();
`ifdef MULDIV_DIV_EN
    test_divide();
`else
    test_divide_disabled();
`endif
    test_start_held();
    test_abort_rst();
    test_abort_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish exp finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle unsigned multiply/divide controller for the MIPS pipeline's HI/LO unit.
- Borrows the shared 32-bit ALU for one add or subtract per cycle and performs a 32-iteration shift-add multiply or restoring divide.
- Holds the 64-bit HI/LO result registers.
- Sits beside the EX stage. The pipeline stalls on `busy`, and the ALU operand mux selects this block while `aluOwn` is high.

Parameters:
- CTL_ADD, 3'b010, ALU control code for A+B.
- CTL_SUB, 3'b110, ALU control code for A-B (invertB with carry-in 1).
- ITER, 32, iteration count. Fixed at the 32-bit width; other values are not supported.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  launch request. Sampled only in IDLE.
- op  in  1  0 = multiply (MULTU), 1 = divide (DIVU).
- flush  in  1  synchronous abort from hazard or exception logic.
- srcA  in  32  multiplicand / dividend.
- srcB  in  32  multiplier / divisor.
- aluResult  in  32  dataOut of the shared ALU.
- aluA  out  32  ALU dataA drive.
- aluB  out  32  ALU dataB drive.
- aluCtl  out  3  ALU ctl drive.
- aluOwn  out  1  high while this block owns the ALU.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset (async, rst=1):
  - State IDLE, iteration count 0.
  - hi, lo, aluA, aluB, busy, done, aluOwn all 0; aluCtl = CTL_ADD.
  - Reset mid-operation discards the operation. No done is produced.
- States: IDLE, RUN, DONE.
  - IDLE: busy=0, aluOwn=0, aluA=aluB=0, aluCtl=CTL_ADD. If start=1 at an edge:
    - Latch operand register M ← srcB and the operation type.
    - Multiply: hi ← 0, lo ← srcA.
    - Divide: hi ← 0, lo ← srcA.
    - count ← 0; next state RUN.
  - RUN: busy=1, aluOwn=1. One iteration per edge, count increments. After the edge where count reaches ITER-1, go to DONE.
  - DONE: busy=1, aluOwn=0, done=1 for exactly one cycle. Next edge goes to IDLE. A start in DONE is ignored.
- Multiply iteration (RUN, op=0):
  - aluA = hi, aluB = M, aluCtl = CTL_ADD.
  - Carry c = (hi[31]&M[31]) | ((hi[31]|M[31]) & ~aluResult[31]).
  - If lo[0]=1, t = {c, aluResult}; else t = {1'b0, hi}.
  - Update: hi ← t[32:1], lo ← {t[0], lo[31:1]}.
- Divide iteration (RUN, op=1), restoring:
  - r = {hi[30:0], lo[31]}; aluA = r, aluB = M, aluCtl = CTL_SUB.
  - No-borrow nb = (r[31]&~M[31]) | (~(r[31]^M[31]) & ~aluResult[31]).
  - If hi[31]=1 or nb=1: hi ← aluResult, lo ← {lo[30:0], 1}.
  - Otherwise: hi ← r, lo ← {lo[30:0], 0}.
  - Final result: lo = quotient, hi = remainder.
- Divide by zero: no special case. The algorithm naturally yields lo=0xFFFFFFFF and hi=dividend.
- Latency: start accepted at edge N; iterations occur at edges N+1..N+32; done is high in the cycle after edge N+32. Total 33 cycles from start to done; IDLE is re-entered at edge N+33.
- hi/lo during RUN hold partial values. Consumers read them only after done or while IDLE.
- start while busy=1: ignored. No queueing; operands are not re-latched.
- flush=1 in RUN or DONE: next edge goes to IDLE.
  - done is not asserted (it is forced low in the same cycle if in DONE).
  - hi/lo keep their current (partial) values.
  - flush in IDLE has priority over start: the start is dropped.
- Both ALU carry/borrow terms are derived from operand and result MSBs. No ALU carry port is required.

Optional Feature:
- Macro MULDIV_DIV_EN.
- Defined: op=1 performs the restoring divide described above.
- Undefined:
  - Divide datapath and CTL_SUB usage are removed.
  - op is ignored and every start performs a multiply.
  - aluCtl is never CTL_SUB.

Test Plan:
- Multiply maximum: op=0, srcA=0xFFFFFFFF, srcB=0xFFFFFFFF, start one cycle → done exactly 33 cycles after start; hi=0xFFFFFFFE, lo=0x00000001; busy low the following cycle.
- Divide basic: op=1, srcA=100, srcB=7 → lo=14, hi=2 at done. Also srcA=0x80000000, srcB=3 → lo=0x2AAAAAAA, hi=2.
- Divide by zero: op=1, srcA=0x12345678, srcB=0 → lo=0xFFFFFFFF, hi=0x12345678; done at 33 cycles.
- start held high through an operation (srcA=6, srcB=7, op=0), with operands changed mid-run → single result hi=0, lo=42; new operation begins only from IDLE after done; no second done until 33 cycles after re-acceptance.
- Abort: start multiply, assert rst at cycle 10 → all outputs 0 immediately (asynchronous). Repeat with flush at cycle 10 → IDLE next edge, no done pulse, aluOwn low.
- Ownership: during RUN, aluCtl alternates correctly per op (CTL_ADD for multiply, CTL_SUB for divide) and aluOwn=1 for exactly 32 cycles. With MULDIV_DIV_EN undefined, op=1 with 5×9 → lo=45.
